// File: rtl/fetch_decode_queue_pkg.sv
// fetch_decode_queue_pkg: entry type and default depth for the fetch/decode queue
package fetch_decode_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fd_entry_t;
  localparam int FDQ_DEPTH = 4;
endpackage

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: first-word fall-through queue of {pc, instr} pairs from fetch to decode
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] level
);
  fd_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  assign in_ready  = (count != CNT_W'(DEPTH)) & ~reset;
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_pc    = out_valid ? mem[rd_ptr].pc : '0;
  assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
  assign level     = count;
  always_ff @(posedge clk)
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
    end
  // storage is not cleared on reset; count gates visibility
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: random and directed stimulus checked against a queue-based reference model
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;
  localparam int DEPTH = FDQ_DEPTH;
  logic clk = 0, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [2:0] level;
  int vectors = 0, miscompares = 0;
  fd_entry_t q[$];
  fetch_decode_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_ready(out_ready), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic ordy);
    logic er, ev, ps, pp;
    logic [31:0] ins;
    ins = pc ^ 32'h5a5a_0000 ^ $urandom;
    reset = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
    @(negedge clk);
    er = (q.size() != DEPTH) && !r;
    ev = q.size() != 0;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_pc", out_pc, ev ? q[0].pc : 32'h0);
    chk("out_instr", out_instr, ev ? q[0].instr : 32'h0);
    chk("level", 32'(level), 32'(q.size()));
    chk("level_bound", 32'(level <= 3'(DEPTH)), 32'd1);
    ps = iv && er && !f;
    pp = ev && ordy && !f;
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (ps) q.push_back('{pc: pc, instr: ins});
    end
    #1;
  endtask
  initial begin
    reset = 1; flush = 0; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0;
    @(posedge clk); #1;
    step(1, 0, 1, 32'hdead0000, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hbfc00000 + 32'(4 * i), 0);
    step(0, 0, 1, 32'hbfc0000c, 0);
    step(0, 0, 1, 32'hbfc00010, 0);
    step(0, 0, 1, 32'hbfc00010, 0);
    step(0, 0, 1, 32'hbfc00014, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'hbfc00000 + 32'(4 * i), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h00400000 + 32'(4 * i), 0);
    step(0, 1, 1, 32'h80000000, 0);
    step(0, 0, 1, 32'h80000000, 0);
    step(0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 32'h00500000 + 32'(4 * i), 0);
    step(1, 0, 1, 32'h00600000, 0);
    step(0, 0, 1, 32'h00700000, 0);
    step(0, 0, 1, 32'h00700004, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
           32'h00400000 + 32'(4 * i), $urandom_range(2) != 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'h0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
